pc_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline: owns the program counter, issues one instruction-memory request at a time, and presents each fetched instruction with its PC to the IF/ID pipeline register. Handles back-pressure from ID (stall), branch redirects from later stages, and discarding an in-flight fetch made stale by a redirect. A one-entry skid buffer absorbs a response that arrives while ID is stalled.

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/fetch_skid.sv | 36 +++
 rtl/pc_fetch.sv | 143 ++++++++++++++
 tb/tb_pc_fetch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: widths, reset/NOP constants and the fetch FSM state type.
package pipeline_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry {pc, inst} holding register for a fetch response that arrives while ID is stalled.
module fetch_skid
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic              flush,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [INST_W-1:0] load_inst,
    output logic [ADDR_W-1:0] pc,
    output logic [INST_W-1:0] inst,
    output logic              valid
);

    // flush (redirect) wins over load and drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= '0;
            inst  <= NOP_INST;
            valid <= 1'b0;
        end else if (flush) begin
            inst  <= NOP_INST;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= load_pc;
            inst  <= load_inst;
            valid <= 1'b1;
        end else if (drain) begin
            inst  <= NOP_INST;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC, single outstanding imem request, IF/ID output slot and skid.
// Optional FETCH_ALIGN_CHECK_EN adds the fetch_misalign flag for misaligned redirect targets.
module pc_fetch
    import pipeline_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic              fetch_misalign,
`endif
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] target;
    logic              slot_free;

    logic              skid_load;
    logic              skid_drain;
    logic              skid_flush;
    logic [ADDR_W-1:0] skid_pc;
    logic [INST_W-1:0] skid_inst;
    logic              skid_valid;

    assign target    = br_target & ~ADDR_W'(3);
    assign slot_free = !if_valid || !stall;
    assign imem_req  = (state == ST_FETCH) || (state == ST_DROP);
    assign imem_addr = req_addr;

    always_comb begin
        skid_flush = br_taken;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        if (!br_taken) begin
            skid_load  = (state == ST_FETCH) && imem_ack && !slot_free;
            skid_drain = (state == ST_HOLD) && !stall;
        end
    end

    fetch_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .drain     (skid_drain),
        .flush     (skid_flush),
        .load_pc   (req_addr),
        .load_inst (imem_rdata),
        .pc        (skid_pc),
        .inst      (skid_inst),
        .valid     (skid_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            if_pc    <= '0;
            if_inst  <= NOP_INST;
            if_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_misalign <= 1'b0;
`endif
        end else begin
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_misalign <= br_taken && (br_target[1:0] != 2'b00);
`endif
            if (br_taken) begin
                pc       <= target;
                if_valid <= 1'b0;
                if_inst  <= NOP_INST;
                unique case (state)
                    ST_IDLE: begin
                        req_addr <= target;
                        state    <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        // an unacked request must still complete; its data is dropped later
                        if (imem_ack) req_addr <= target;
                        else          state    <= ST_DROP;
                    end
                    ST_HOLD: begin
                        req_addr <= target;
                        state    <= ST_FETCH;
                    end
                    ST_DROP: ;
                endcase
            end else begin
                if (!stall) begin
                    if_valid <= 1'b0;
                    if_inst  <= NOP_INST;
                end
                unique case (state)
                    ST_IDLE: begin
                        req_addr <= pc;
                        state    <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        if (imem_ack) begin
                            pc       <= pc + ADDR_W'(4);
                            req_addr <= pc + ADDR_W'(4);
                            if (slot_free) begin
                                if_pc    <= req_addr;
                                if_inst  <= imem_rdata;
                                if_valid <= 1'b1;
                            end else begin
                                state <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!stall) begin
                            if_pc    <= skid_pc;
                            if_inst  <= skid_inst;
                            if_valid <= skid_valid;
                            state    <= ST_FETCH;
                        end
                    end
                    ST_DROP: begin
                        if (imem_ack) begin
                            req_addr <= pc;
                            state    <= ST_FETCH;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: queue-based fetch model, randomized memory latency/stall/redirect.
module tb_pc_fetch;

    localparam logic [31:0] K = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst, stall, br_taken, imem_req, imem_ack, if_valid;
    logic [31:0] br_target, imem_addr, imem_rdata, if_pc, if_inst;
    logic        fetch_misalign;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    bit          started, stale, checking, force_ack, prev_b;
    logic [31:0] m_pc, m_req_addr, m_last_pc;
    logic        m_mis;
    int          lat_cnt;
    int          lat_fixed;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
`ifdef FETCH_ALIGN_CHECK_EN
        .fetch_misalign (fetch_misalign),
`endif
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .if_valid   (if_valid)
    );

`ifndef FETCH_ALIGN_CHECK_EN
    assign fetch_misalign = 1'b0;
`endif

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // A request is live once started, unless both slot and skid are occupied.
    function automatic bit exp_req();
        return started && (q.size() < 2);
    endfunction

    function automatic int new_lat();
        return (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
    endfunction

    task automatic model_reset();
        q.delete();
        started    = 1'b0;
        stale      = 1'b0;
        m_pc       = 32'h0;
        m_req_addr = 32'h0;
        m_last_pc  = 32'h0;
        m_mis      = 1'b0;
    endtask

    task automatic model_update();
        logic [31:0] tgt;
        bit live;
        tgt   = br_target & ~32'h3;
        live  = exp_req();
        m_mis = br_taken && (br_target[1:0] != 2'b00);
        if (!started) begin
            started    = 1'b1;
            m_req_addr = m_pc;
            if (br_taken) begin
                m_pc       = tgt;
                m_req_addr = tgt;
            end
        end else if (br_taken) begin
            q.delete();
            m_pc = tgt;
            if (!live) m_req_addr = tgt;
            else if (!stale) begin
                if (imem_ack) m_req_addr = tgt;
                else          stale = 1'b1;
            end
        end else begin
            if (q.size() > 0 && !stall) void'(q.pop_front());
            if (live && imem_ack) begin
                if (stale) begin
                    stale      = 1'b0;
                    m_req_addr = m_pc;
                end else begin
                    q.push_back('{m_req_addr, imem_rdata});
                    m_pc       = m_pc + 32'd4;
                    m_req_addr = m_pc;
                end
            end
        end
        if (q.size() > 0) m_last_pc = q[0].pc;
    endtask

    task automatic drive(input bit s, input bit b, input logic [31:0] t);
        stall      = s;
        br_taken   = b;
        br_target  = t;
        imem_ack   = force_ack || (exp_req() && lat_cnt == 0);
        imem_rdata = imem_ack ? (imem_addr ^ K) : $urandom();
        force_ack  = 1'b0;
    endtask

    task automatic step();
        bit was_live;
        was_live = exp_req();
        @(posedge clk);
        #1;
        if (imem_ack)      lat_cnt = new_lat();
        else if (was_live) lat_cnt--;
        if (!rst) model_update();
    endtask

    // Reset held two edges; a stray ack is offered during the IDLE cycle that follows.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        lat_cnt = new_lat();
        drive(1'b0, 1'b0, 32'h0);
        step();
        step();
        rst       = 1'b0;
        force_ack = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
            check("imem_addr", imem_addr, m_req_addr);
            check("if_valid", {31'b0, if_valid}, {31'b0, (q.size() > 0)});
            check("if_pc", if_pc, m_last_pc);
            check("if_inst", if_inst, (q.size() > 0) ? q[0].inst : 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
            check("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, m_mis});
`endif
        end
    end

    initial begin
        checking  = 1'b0;
        force_ack = 1'b0;
        prev_b    = 1'b0;
        lat_fixed = 0;
        rst       = 1'b1;
        model_reset();
        lat_cnt = 0;
        drive(1'b0, 1'b0, 32'h0);
        checking = 1'b1;
        step();
        step();
        check("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);

        rst       = 1'b0;
        force_ack = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        step();
        check("a_imem_req", {31'b0, imem_req}, 32'h1);
        check("a_imem_addr", imem_addr, 32'h0);
        check("a_if_valid", {31'b0, if_valid}, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        step();
        check("b_if_valid", {31'b0, if_valid}, 32'h1);
        check("b_if_pc", if_pc, 32'h0);
        check("b_if_inst", if_inst, 32'hC0DE_0000);
        check("b_imem_addr", imem_addr, 32'h4);
        drive(1'b0, 1'b0, 32'h0);
        step();
        check("c_if_pc", if_pc, 32'h4);
        check("c_if_inst", if_inst, 32'hC0DE_0004);
        check("c_imem_addr", imem_addr, 32'h8);
        drive(1'b0, 1'b1, 32'h0000_0102);
        step();
        check("d_if_valid", {31'b0, if_valid}, 32'h0);
        check("d_if_inst", if_inst, 32'h0);
        check("d_if_pc", if_pc, 32'h4);
        check("d_imem_addr", imem_addr, 32'h100);
`ifdef FETCH_ALIGN_CHECK_EN
        check("d_misalign", {31'b0, fetch_misalign}, 32'h1);
`endif
        drive(1'b0, 1'b0, 32'h0);
        step();
        check("e_if_valid", {31'b0, if_valid}, 32'h1);
        check("e_if_pc", if_pc, 32'h100);
        check("e_if_inst", if_inst, 32'hC0DE_0100);
        check("e_imem_addr", imem_addr, 32'h104);
`ifdef FETCH_ALIGN_CHECK_EN
        check("e_misalign", {31'b0, fetch_misalign}, 32'h0);
`endif

        lat_fixed = -1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                prev_b = 1'b0;
            end else begin
                bit s, b;
                s = ($urandom_range(0, 2) == 0);
                b = !prev_b && ($urandom_range(0, 9) == 0);
                prev_b = b;
                drive(s, b, $urandom());
            end
            step();
        end

        drive(1'b0, 1'b0, 32'h0);
        step();
        step();
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
